spi_slave_fifo: RTL and testbench
=================================

SPI_SLAVE_FIFO -- requirements
Module: spi_slave_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per SPI word, legal range >=2.
REQ-002 SHALL have parameter DEPTH, default 4: entries per TX and RX FIFO, power of 2, >=2.
REQ-003 SHALL have parameter CPOL, default 0: idle level of sclk.
REQ-004 SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 SHALL have parameter TX_IDLE, default 0 (WIDTH bits): word shifted out when the TX FIFO is empty.
REQ-006 SHALL have port clk, input, 1: system clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have ports sclk, cs_n and mosi, each input, 1: asynchronous SPI pins.
REQ-009 SHALL have ports miso, output, 1, and miso_oe, output, 1: serial data and its output enable (high while selected).
REQ-010 SHALL have ports tx_data (input, WIDTH), tx_valid (input, 1) and tx_ready (output, 1): TX FIFO push handshake.
REQ-011 SHALL have ports rx_data (output, WIDTH), rx_valid (output, 1) and rx_ready (input, 1): RX FIFO first-word-fall-through pop handshake.
REQ-012 SHALL have ports tx_level and rx_level, output, clog2(DEPTH)+1 each: FIFO occupancy.
REQ-013 SHALL have ports tx_underrun and rx_overrun, output, 1 each: single-cycle error pulses.

Function
REQ-014 SHALL pass sclk, cs_n and mosi through 2-flop synchronisers; all edge detection uses synced sclk versus a 1-cycle-delayed copy.
REQ-015 SHALL define the leading edge as synced sclk leaving CPOL and the trailing edge as its return to CPOL; edges are ignored while synced cs_n is high.
REQ-016 SHALL treat the sample edge as leading when CPHA=0 and trailing when CPHA=1; the shift edge is the other edge.
REQ-017 SHALL, on each sample edge, shift synced mosi into the RX shift register MSB-first and increment bit_cnt.
REQ-018 SHALL push the assembled word into the RX FIFO in the cycle after bit_cnt reaches WIDTH, then clear bit_cnt.
REQ-019 SHALL, if the RX FIFO is full at push time and no pop occurs in that cycle, drop the word and pulse rx_overrun for 1 cycle; a push and pop in the same cycle at full SHALL both succeed.
REQ-020 SHALL perform a TX load as follows. CPHA=0: on synced cs_n falling and on the first shift edge after a completed word. CPHA=1: on a shift edge with bit_cnt=0.
REQ-021 SHALL, on a TX load, pop the TX FIFO head into the TX shift register and drive its MSB on miso the next cycle; if the TX FIFO is empty, load TX_IDLE and pulse tx_underrun.
REQ-022 SHALL, on each non-load shift edge, drive the next bit (MSB-first) onto miso.
REQ-023 SHALL hold tx_ready = not full; a push occurs when tx_valid and tx_ready are both high in the same cycle.
REQ-024 SHALL hold rx_valid = not empty and rx_data = the head entry; a pop occurs when rx_valid and rx_ready are both high.
REQ-025 SHALL update tx_level and rx_level in the cycle after a push or pop; a simultaneous push and pop SHALL leave the level unchanged.
REQ-026 SHALL wrap FIFO pointers modulo DEPTH, with levels in the range 0..DEPTH.
REQ-027 SHALL, on synced cs_n rising mid-word, discard the partial RX bits, clear bit_cnt, and lose the partial TX word without re-queueing it; FIFOs are unaffected.
REQ-028 SHALL hold miso_oe = not synced cs_n; miso SHALL be 0 while deselected.

Reset
REQ-029 SHALL, on rst, empty both FIFOs, clear bit_cnt and shift registers, and drive miso=0, miso_oe=0, tx_ready=1, rx_valid=0, levels=0, tx_underrun=0 and rx_overrun=0.
REQ-030 SHALL, if rst is asserted while cs_n is low, ignore the rest of that transaction; operation SHALL resume only after synced cs_n is seen high and then falls again.

Verification
REQ-031 SHALL cover: CPOL=0/CPHA=0 with TX pushed 0xA5, master sends 0x3C -> master reads 0xA5, rx_data=0x3C, rx_level=1.
REQ-032 SHALL cover: all four CPOL/CPHA modes with 3 back-to-back words 0x01,0x02,0x03 in one cs_n frame -> identical data both directions in every mode.
REQ-033 SHALL cover: TX FIFO empty with TX_IDLE=0xFF -> master reads 0xFF and tx_underrun pulses exactly once per word.
REQ-034 SHALL cover: 5 words received with DEPTH=4 and no pops -> rx_level=4, one rx_overrun pulse, and the FIFO holds words 1-4.
REQ-035 SHALL cover: cs_n raised after 3 bits, then a full word 0x5A -> only 0x5A is pushed and rx_level=1.
REQ-036 SHALL cover: rst pulsed mid-word with cs_n held low -> no RX push until cs_n toggles; all outputs equal their REQ-029 reset values.

Source files
------------

// File: rtl/spi_slave_fifo.sv
// SPI slave with TX and RX FIFOs; SPI pins are oversampled and synchronised to clk.
// MSB-first, with the CPOL/CPHA mode chosen by parameter.
module spi_slave_fifo #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 4,
  parameter bit               CPOL    = 1'b0,
  parameter bit               CPHA    = 1'b0,
  parameter logic [WIDTH-1:0] TX_IDLE = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sclk,
  input  logic                   cs_n,
  input  logic                   mosi,
  output logic                   miso,
  output logic                   miso_oe,
  input  logic [WIDTH-1:0]       tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [WIDTH-1:0]       rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [$clog2(DEPTH):0] tx_level,
  output logic [$clog2(DEPTH):0] rx_level,
  output logic                   tx_underrun,
  output logic                   rx_overrun
);
  localparam int unsigned   PW        = $clog2(DEPTH);
  localparam int unsigned   CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] BITS_FULL = CW'(WIDTH);
  localparam logic [PW:0]   LVL_FULL  = (PW + 1)'(DEPTH);

  logic sclk_meta, sclk_sync, sclk_prev;
  logic cs_meta, cs_sync, cs_prev;
  logic mosi_meta, mosi_sync;
  logic armed;

  // Synchronisers stay unreset so 'armed' sees the true cs_n level right after rst.
  always_ff @(posedge clk) begin
    sclk_meta <= sclk;
    sclk_sync <= sclk_meta;
    sclk_prev <= sclk_sync;
    cs_meta   <= cs_n;
    cs_sync   <= cs_meta;
    cs_prev   <= cs_sync;
    mosi_meta <= mosi;
    mosi_sync <= mosi_meta;
  end

  // A transaction cut by rst is ignored until cs_n has been seen high again.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (cs_sync) begin
      armed <= 1'b1;
    end
  end

  logic          sel, lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, cs_rise;
  logic          word_done, tx_load;
  logic [CW-1:0] bit_cnt;
  logic [WIDTH-1:0] rx_shift, tx_shift;

  assign sel         = armed & ~cs_sync;
  assign lead_edge   = sel & (sclk_sync != CPOL) & (sclk_prev == CPOL);
  assign trail_edge  = sel & (sclk_sync == CPOL) & (sclk_prev != CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = sel & cs_prev;
  assign cs_rise     = cs_sync & ~cs_prev;
  assign word_done   = (bit_cnt == BITS_FULL);
  // A shift edge sees bit_cnt==0 only at word start (CPHA=1) or just after a finished word (CPHA=0).
  assign tx_load     = (shift_edge & (bit_cnt == '0)) | (~CPHA & cs_fall);

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else if (cs_rise) begin
      bit_cnt <= '0;
    end else if (sample_edge) begin
      rx_shift <= {rx_shift[WIDTH-2:0], mosi_sync};
      bit_cnt  <= word_done ? CW'(1) : bit_cnt + 1'b1;
    end else if (word_done) begin
      bit_cnt <= '0;
    end
  end

  // TX FIFO
  logic [WIDTH-1:0] tx_mem [DEPTH];
  logic [PW-1:0]    tx_wr_ptr, tx_rd_ptr;
  logic             tx_push, tx_pop, tx_empty;

  assign tx_empty = (tx_level == '0);
  assign tx_ready = (tx_level != LVL_FULL);
  assign tx_push  = tx_valid & tx_ready;
  assign tx_pop   = tx_load & ~tx_empty;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_level  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_level <= tx_level + 1'b1;
        2'b01:   tx_level <= tx_level - 1'b1;
        default: tx_level <= tx_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift    <= '0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= tx_load & tx_empty;
      if (tx_load) begin
        tx_shift <= tx_empty ? TX_IDLE : tx_mem[tx_rd_ptr];
      end else if (shift_edge) begin
        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign miso    = sel & tx_shift[WIDTH-1];
  assign miso_oe = sel;

  // RX FIFO, first-word-fall-through
  logic [WIDTH-1:0] rx_mem [DEPTH];
  logic [PW-1:0]    rx_wr_ptr, rx_rd_ptr;
  logic             rx_pop, rx_wr, rx_full;

  assign rx_full  = (rx_level == LVL_FULL);
  assign rx_valid = (rx_level != '0);
  assign rx_data  = rx_mem[rx_rd_ptr];
  assign rx_pop   = rx_valid & rx_ready;
  // At full a same-cycle pop frees the slot being written.
  assign rx_wr    = word_done & (~rx_full | rx_pop);

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      rx_level   <= '0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= word_done & rx_full & ~rx_pop;
      if (rx_wr)  rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop) rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_wr, rx_pop})
        2'b10:   rx_level <= rx_level + 1'b1;
        2'b01:   rx_level <= rx_level - 1'b1;
        default: rx_level <= rx_level;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: one DUT per SPI mode, a bit-banged master, and a queue model of
// what each frame must exchange in both directions.
module tb_spi_slave_fifo;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      sclk = 4'b1100;
  logic [3:0]      cs_n = 4'hF;
  logic            mosi = 1'b0;
  logic [3:0]      miso, miso_oe, tx_ready, rx_valid, tx_underrun, rx_overrun;
  logic [3:0]      tx_valid = 4'h0;
  logic [3:0]      rx_ready = 4'h0;
  logic [7:0]      tx_data = 8'h00;
  logic [3:0][7:0] rx_data;
  logic [3:0][2:0] tx_level, rx_level;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_fifo #(
      .WIDTH(8), .DEPTH(4), .CPOL((g / 2) != 0), .CPHA((g % 2) != 0), .TX_IDLE(8'hFF)
    ) u_dut (
      .clk(clk), .rst(rst), .sclk(sclk[g]), .cs_n(cs_n[g]), .mosi(mosi),
      .miso(miso[g]), .miso_oe(miso_oe[g]),
      .tx_data(tx_data), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
      .rx_data(rx_data[g]), .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]),
      .tx_level(tx_level[g]), .rx_level(rx_level[g]),
      .tx_underrun(tx_underrun[g]), .rx_overrun(rx_overrun[g])
    );
  end

  int und_cnt [4];
  int ovr_cnt [4];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (tx_underrun[i]) und_cnt[i] <= und_cnt[i] + 1;
      if (rx_overrun[i])  ovr_cnt[i] <= ovr_cnt[i] + 1;
    end
  end

  logic [7:0] exp_tx[$], exp_rx[$], send_q[$], got_q[$], exp_rd[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_tx.delete();
    exp_rx.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset(input int m);
    check_eq("rst_miso", miso[m], 0);
    check_eq("rst_miso_oe", miso_oe[m], 0);
    check_eq("rst_tx_ready", tx_ready[m], 1);
    check_eq("rst_rx_valid", rx_valid[m], 0);
    check_eq("rst_tx_level", tx_level[m], 0);
    check_eq("rst_rx_level", rx_level[m], 0);
    check_eq("rst_underrun", tx_underrun[m], 0);
    check_eq("rst_overrun", rx_overrun[m], 0);
  endtask

  task automatic push_tx(input int m, input logic [7:0] v);
    @(negedge clk);
    check_eq("tx_ready", tx_ready[m], exp_tx.size() < 4);
    tx_data     = v;
    tx_valid[m] = 1'b1;
    @(negedge clk);
    tx_valid[m] = 1'b0;
    if (exp_tx.size() < 4) exp_tx.push_back(v);
  endtask

  task automatic pop_rx(input int m);
    logic [7:0] v;
    @(negedge clk);
    check_eq("rx_valid", rx_valid[m], exp_rx.size() != 0);
    if (exp_rx.size() != 0) begin
      v = exp_rx.pop_front();
      check_eq("rx_data", rx_data[m], v);
    end
    rx_ready[m] = 1'b1;
    @(negedge clk);
    rx_ready[m] = 1'b0;
  endtask

  // Master: sends nbits of w MSB-first and returns what it sampled on miso.
  task automatic xfer_word(input int m, input logic [7:0] w, input int nbits,
                           output logic [7:0] rd);
    logic cpol, cpha;
    cpol = (m / 2) != 0;
    cpha = (m % 2) != 0;
    rd   = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi = w[i];
        half();
        sclk[m] = ~cpol;
        rd[i]   = miso[m];
        half();
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi    = w[i];
        half();
        sclk[m] = cpol;
        rd[i]   = miso[m];
        half();
      end
    end
  endtask

  task automatic run_frame(input int m, input int nwords, input int part_bits);
    logic [7:0] rd;
    got_q.delete();
    cs_n[m] = 1'b0;
    half();
    for (int w = 0; w < nwords; w++) begin
      xfer_word(m, send_q[w], 8, rd);
      got_q.push_back(rd);
    end
    if (part_bits > 0) xfer_word(m, 8'($urandom), part_bits, rd);
    half();
    cs_n[m] = 1'b1;
    half();
    half();
  endtask

  // Model: CPHA=0 loads at cs fall and after every full word; CPHA=1 loads at each word start.
  task automatic frame_and_check(input int m, input int nwords, input int part_bits);
    int und0, ovr0, loads, exp_und, exp_ovr;
    logic [7:0] v;
    und0    = und_cnt[m];
    ovr0    = ovr_cnt[m];
    exp_und = 0;
    exp_ovr = 0;
    run_frame(m, nwords, part_bits);
    loads = ((m % 2) == 0) ? nwords + 1 : nwords + ((part_bits > 0) ? 1 : 0);
    exp_rd.delete();
    for (int l = 0; l < loads; l++) begin
      if (exp_tx.size() > 0) v = exp_tx.pop_front();
      else begin
        v = 8'hFF;
        exp_und++;
      end
      exp_rd.push_back(v);
    end
    for (int w = 0; w < nwords; w++) begin
      if (exp_rx.size() < 4) exp_rx.push_back(send_q[w]);
      else exp_ovr++;
    end
    for (int w = 0; w < nwords; w++) check_eq("miso_word", got_q[w], exp_rd[w]);
    check_eq("underruns", und_cnt[m] - und0, exp_und);
    check_eq("overruns", ovr_cnt[m] - ovr0, exp_ovr);
    check_eq("rx_level", rx_level[m], exp_rx.size());
    check_eq("tx_level", tx_level[m], exp_tx.size());
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int u0, o0, np, nw;
    for (int m = 0; m < 4; m++) begin
      do_reset();
      check_reset(m);
      for (int i = 1; i <= 3; i++) push_tx(m, 8'(i));
      send_q = '{8'h01, 8'h02, 8'h03};
      frame_and_check(m, 3, 0);
      for (int i = 0; i < 3; i++) check_eq("b2b_read", got_q[i], i + 1);
      for (int i = 0; i < 3; i++) pop_rx(m);

      do_reset();
      send_q = '{8'($urandom), 8'($urandom)};
      u0 = und_cnt[m];
      frame_and_check(m, 2, 0);
      check_eq("idle_read", got_q[1], 8'hFF);
      if ((m % 2) == 1) check_eq("und_per_word", und_cnt[m] - u0, 2);

      for (int r = 0; r < 6; r++) begin
        np = $urandom_range(0, 5);
        nw = $urandom_range(1, 3);
        for (int i = 0; i < np; i++) push_tx(m, 8'($urandom));
        send_q.delete();
        for (int i = 0; i < nw; i++) send_q.push_back(8'($urandom));
        frame_and_check(m, nw, 0);
        np = $urandom_range(0, 4);
        for (int i = 0; i < np; i++) pop_rx(m);
      end
    end

    do_reset();
    push_tx(0, 8'hA5);
    send_q = '{8'h3C};
    frame_and_check(0, 1, 0);
    check_eq("a5_read", got_q[0], 8'hA5);
    check_eq("rx_3c", rx_data[0], 8'h3C);
    check_eq("rx_level_1", rx_level[0], 1);

    do_reset();
    o0 = ovr_cnt[0];
    send_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    frame_and_check(0, 5, 0);
    check_eq("ovf_level", rx_level[0], 4);
    check_eq("ovf_pulses", ovr_cnt[0] - o0, 1);
    for (int i = 0; i < 4; i++) begin
      check_eq("ovf_word", rx_data[0], i + 1);
      pop_rx(0);
    end

    do_reset();
    frame_and_check(0, 0, 3);
    send_q = '{8'h5A};
    frame_and_check(0, 1, 0);
    check_eq("abort_level", rx_level[0], 1);
    check_eq("abort_data", rx_data[0], 8'h5A);

    do_reset();
    cs_n[0] = 1'b0;
    half();
    xfer_word(0, 8'hC3, 3, rd);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_tx.delete();
    exp_rx.delete();
    u0 = und_cnt[0];
    xfer_word(0, 8'hC3, 8, rd);
    half();
    check_reset(0);
    check_eq("ignored_underrun", und_cnt[0] - u0, 0);
    cs_n[0] = 1'b1;
    half();
    half();
    send_q = '{8'h77};
    frame_and_check(0, 1, 0);
    check_eq("resume_data", rx_data[0], 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
